onebit_run_ctrl: RTL and testbench
==================================

Name: onebit_run_ctrl

Overview:
Run controller for the one-bit toggle CPU core.
- Owns the core's 2-entry instruction store and drives the core's instruction input from it.
- Sequences the core through its active-low synchronous reset: holds it in reset, releases it for exactly N steps, captures the accumulator, then re-asserts reset.
- Sits between a host (program writes, start/abort, result readback) and a single core instance.

Parameters:
LEN_W, 8, width of run-length field; max run is 2**LEN_W-1 steps

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low; all state and outputs to reset values
prog_we  input  1  host program write strobe
prog_addr  input  1  program word index
prog_wdata  input  1  program bit (1 = toggle, 0 = hold)
start  input  1  run request; sampled only in IDLE or DONE
run_len  input  LEN_W  step count N, sampled with accepted start
abort  input  1  cancel an active run
busy  output  1  high in RUN or CAPTURE
done  output  1  high in DONE (level)
result  output  1  captured core accumulator
wr_err  output  1  one-cycle pulse: prog_we while busy (write dropped)
cpu_rst_n  output  1  registered reset to core, active-low
cpu_addr  input  1  core instruction address
cpu_a  input  1  core accumulator
cpu_data  output  1  instruction bit to core

Behaviour:
Reset (reset=0 at an edge):
- state=IDLE, prog=2'b00, cpu_rst_n=0, result=0, done=0, busy=0, wr_err=0, counter=0.

Instruction path:
- cpu_data = prog[cpu_addr], purely combinational, in every state.

Program store:
- prog_we in IDLE or DONE: prog[prog_addr] <= prog_wdata at that edge.
- prog_we in RUN or CAPTURE: write dropped; wr_err=1 in the following cycle only.

States:
- IDLE: cpu_rst_n=0.
  - start with run_len>0 -> RUN; counter <= run_len; cpu_rst_n <= 1.
  - start with run_len==0 -> CAPTURE; cpu_rst_n stays 0.
- RUN: each edge is one core step; counter decrements.
  - At the edge where counter==1 -> CAPTURE; cpu_rst_n <= 0.
  - The core still steps on that edge, so exactly N steps are executed.
- CAPTURE: one cycle. cpu_a holds the post-N-step value.
  - Next edge: result <= cpu_a; the core resets; state -> DONE.
- DONE: done=1, cpu_rst_n=0, result held.
  - start -> same transitions as from IDLE; done drops at that edge.
  - result held until the next CAPTURE.

Latency:
- Start accepted at edge E0.
- done visible after edge E(N+1): RUN lasts N cycles, CAPTURE 1 cycle.
- run_len==0: done after E1 with result=0.

Abort:
- abort in RUN or CAPTURE -> IDLE; cpu_rst_n <= 0; result unchanged; done stays 0.
- abort in IDLE or DONE: ignored.
- abort and start in the same cycle in DONE: abort ignored, start wins.

Other rules:
- start while busy is ignored.
- Global reset mid-run: core and controller both return to reset state; program contents lost.
- Counter width is LEN_W; no wrap, because the run ends at 1.

Decomposition:
- onebit_pkg:
  - typedef enum run_state_t {IDLE, RUN, CAPTURE, DONE}.
  - PROG_DEPTH=2.
- Sub-module onebit_prog_store:
  - 2x1-bit register with write port and combinational read.
  - Instantiated once, read by cpu_addr.
- Bench top instantiates onebit_run_ctrl plus the core.

Test Plan:
1. Reset, write prog[0]=1, prog[1]=0, start with run_len=3 -> busy for 4 cycles, then done=1, result=0. Core A goes 1,1,0 over the 3 steps.
2. prog=11, run_len=5 -> result=1, done 6 cycles after the start edge; cpu_rst_n high for exactly 5 cycles.
3. prog[0]=0, prog[1]=1: run_len=4 -> result=0; then restart from DONE with run_len=3 -> result=1, done drops at the restart edge.
4. run_len=0 -> cpu_rst_n never rises, result=0, done after 1 cycle.
5. prog_we to addr 0 during RUN -> wr_err pulses 1 cycle, prog unchanged, run result unaffected.
6. abort 2 cycles into a run_len=10 run -> IDLE next edge, done=0, result keeps prior value, cpu_rst_n=0. reset=0 mid-run -> all outputs return to reset values.

Source files
------------

// File: rtl/onebit_pkg.sv
// Shared types and constants for the one-bit toggle CPU run controller.
package onebit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPTURE,
    DONE
  } run_state_t;

  localparam int PROG_DEPTH = 2;

endpackage

// File: rtl/onebit_prog_store.sv
// Two-entry, one-bit instruction store with a single write port and a combinational read port.
module onebit_prog_store
  import onebit_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic we,
  input  logic waddr,
  input  logic wdata,
  input  logic raddr,
  output logic rdata
);

  logic [PROG_DEPTH-1:0] prog;

  always_ff @(posedge clock) begin
    if (!reset) begin
      prog <= '0;
    end else if (we) begin
      prog[waddr] <= wdata;
    end
  end

  assign rdata = prog[raddr];

endmodule

// File: rtl/onebit_run_ctrl.sv
// Run controller: owns the core's program, releases the core from reset for N steps,
// then captures its accumulator and parks it back in reset.
module onebit_run_ctrl
  import onebit_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             prog_we,
  input  logic             prog_addr,
  input  logic             prog_wdata,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             wr_err,
  output logic             cpu_rst_n,
  input  logic             cpu_addr,
  input  logic             cpu_a,
  output logic             cpu_data
);

  run_state_t       state, stateNext;
  logic [LEN_W-1:0] counter, counterNext;
  logic             cpuRstNext, resultNext, wrErrNext, progWrite;

  onebit_prog_store progStore (
    .clock (clock),
    .reset (reset),
    .we    (progWrite),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (cpu_addr),
    .rdata (cpu_data)
  );

  assign busy = (state == RUN) || (state == CAPTURE);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      cpu_rst_n <= 1'b0;
      result    <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state     <= stateNext;
      counter   <= counterNext;
      cpu_rst_n <= cpuRstNext;
      result    <= resultNext;
      wr_err    <= wrErrNext;
    end
  end

  // The core still steps on the edge that leaves RUN, so dropping its reset there gives exactly N steps.
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    cpuRstNext  = cpu_rst_n;
    resultNext  = result;
    progWrite   = 1'b0;
    wrErrNext   = prog_we && busy;
    case (state)
      IDLE, DONE: begin
        progWrite = prog_we;
        if (start) begin
          counterNext = run_len;
          if (run_len != '0) begin
            stateNext  = RUN;
            cpuRstNext = 1'b1;
          end else begin
            stateNext  = CAPTURE;
            cpuRstNext = 1'b0;
          end
        end
      end
      RUN: begin
        if (abort) begin
          stateNext  = IDLE;
          cpuRstNext = 1'b0;
        end else begin
          counterNext = counter - LEN_W'(1);
          if (counter == LEN_W'(1)) begin
            stateNext  = CAPTURE;
            cpuRstNext = 1'b0;
          end
        end
      end
      CAPTURE: begin
        cpuRstNext = 1'b0;
        if (abort) begin
          stateNext = IDLE;
        end else begin
          resultNext = cpu_a;
          stateNext  = DONE;
        end
      end
      default: begin
        stateNext  = IDLE;
        cpuRstNext = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_onebit_run_ctrl.sv
// Directed bench for onebit_run_ctrl driving a behavioural one-bit toggle core.
module tb_onebit_run_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       prog_we = 1'b0, prog_addr = 1'b0, prog_wdata = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [7:0] run_len = '0;
  logic       busy, done, result, wr_err, cpu_rst_n, cpu_data;
  logic       corePc = 1'b0, coreA = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  onebit_run_ctrl #(.LEN_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .run_len    (run_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .wr_err     (wr_err),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_addr   (corePc),
    .cpu_a      (coreA),
    .cpu_data   (cpu_data)
  );

  // Core: PC alternates 0/1 each step; instruction 1 toggles A, 0 holds it.
  always @(posedge clock) begin
    if (!cpu_rst_n) begin
      corePc <= 1'b0;
      coreA  <= 1'b0;
    end else begin
      corePc <= ~corePc;
      if (cpu_data) coreA <= ~coreA;
    end
  end

  task automatic applyStimulus(input logic we, input logic addr, input logic wdata,
                               input logic st, input logic [7:0] len, input logic ab);
    prog_we = we; prog_addr = addr; prog_wdata = wdata;
    start = st; run_len = len; abort = ab;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic writeProg(input logic p0, input logic p1);
    applyStimulus(1'b1, 1'b0, p0, 1'b0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, p1, 1'b0, 8'd0, 1'b0);
    idle();
  endtask

  // Starts a run, waits for done, checks latency, core-release cycles and captured result.
  task automatic runProgram(input string tag, input logic [7:0] len, input int expResult);
    int cycles, highCount;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, len, 1'b0);
    checkOutput({tag, "_busy_at_start"}, int'(busy), 1);
    checkOutput({tag, "_done_at_start"}, int'(done), 0);
    cycles = 0;
    highCount = cpu_rst_n ? 1 : 0;
    while (!done && cycles < 300) begin
      idle();
      cycles++;
      if (cpu_rst_n) highCount++;
    end
    checkOutput({tag, "_latency"}, cycles, int'(len) + 1);
    checkOutput({tag, "_rst_high_cycles"}, highCount, int'(len));
    checkOutput({tag, "_result"}, int'(result), expResult);
    checkOutput({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b0;
    idle(); idle(); idle();
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_result", int'(result), 0);
    checkOutput("reset_wr_err", int'(wr_err), 0);
    checkOutput("reset_cpu_rst_n", int'(cpu_rst_n), 0);
    reset = 1'b1;

    // Test 1: prog 1,0 for three steps; A goes 1,1,0.
    writeProg(1'b1, 1'b0);
    checkOutput("t1_cpu_data_addr0", int'(cpu_data), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
    checkOutput("t1_busy_e0", int'(busy), 1);
    checkOutput("t1_rst_n_e0", int'(cpu_rst_n), 1);
    idle(); checkOutput("t1_a_step1", int'(coreA), 1); checkOutput("t1_busy_e1", int'(busy), 1);
    idle(); checkOutput("t1_a_step2", int'(coreA), 1); checkOutput("t1_busy_e2", int'(busy), 1);
    idle(); checkOutput("t1_a_step3", int'(coreA), 0); checkOutput("t1_busy_e3", int'(busy), 1);
    checkOutput("t1_rst_n_e3", int'(cpu_rst_n), 0);
    idle();
    checkOutput("t1_done", int'(done), 1);
    checkOutput("t1_result", int'(result), 0);
    checkOutput("t1_busy_e4", int'(busy), 0);

    // Test 2: prog 1,1 for five steps.
    writeProg(1'b1, 1'b1);
    runProgram("t2", 8'd5, 1);

    // Test 3: prog 0,1 for four then three steps, restarting from DONE.
    writeProg(1'b0, 1'b1);
    runProgram("t3a", 8'd4, 0);
    runProgram("t3b", 8'd3, 1);

    // Test 4: zero-length run never releases the core.
    runProgram("t4", 8'd0, 0);

    // Test 5: write during RUN is dropped and flagged for one cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    checkOutput("t5_wr_err_pulse", int'(wr_err), 1);
    idle();
    checkOutput("t5_wr_err_clear", int'(wr_err), 0);
    for (int i = 0; i < 10 && !done; i++) idle();
    checkOutput("t5_done", int'(done), 1);
    checkOutput("t5_result", int'(result), 0);
    idle();
    checkOutput("t5_prog0_unchanged", int'(cpu_data), 0);
    checkOutput("t5_no_wr_err_in_done", int'(wr_err), 0);

    // Test 6: abort handling and mid-run global reset.
    writeProg(1'b1, 1'b1);
    runProgram("t6_pre", 8'd5, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    checkOutput("t6_abort_in_done_done", int'(done), 1);
    checkOutput("t6_abort_in_done_result", int'(result), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd10, 1'b1);
    checkOutput("t6_start_beats_abort", int'(busy), 1);
    checkOutput("t6_done_dropped", int'(done), 0);
    idle(); idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    checkOutput("t6_abort_busy", int'(busy), 0);
    checkOutput("t6_abort_done", int'(done), 0);
    checkOutput("t6_abort_result", int'(result), 1);
    checkOutput("t6_abort_rst_n", int'(cpu_rst_n), 0);
    idle();
    checkOutput("t6_idle_stays", int'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd10, 1'b0);
    idle(); idle();
    reset = 1'b0;
    idle();
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_done", int'(done), 0);
    checkOutput("t6_rst_result", int'(result), 0);
    checkOutput("t6_rst_cpu_rst_n", int'(cpu_rst_n), 0);
    idle();
    checkOutput("t6_rst_prog_lost", int'(cpu_data), 0);
    reset = 1'b1;
    idle();
    checkOutput("t6_post_reset_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
